// File: rtl/pwm_decode_if.sv
// pwm_decode_if
// Bundles the PWM decoder's signal-side port: the raw PWM input and the
// decoded results.
//   pwm_in    : asynchronous PWM waveform (driven by master)
//   level     : decoded duty level, WIDTH bits
//   valid     : one-cycle strobe, level updated this cycle
//   frame_err : one-cycle strobe, last frame period was not 2^WIDTH
//   no_signal : flag, timeout since last rising edge
// Modports: master = waveform source / result consumer, slave = decoder.
interface pwm_decode_if #(
   parameter int WIDTH = 8
);
   logic             pwm_in;
   logic [WIDTH-1:0] level;
   logic             valid;
   logic             frame_err;
   logic             no_signal;

   modport master (
      output pwm_in,
      input  level,
      input  valid,
      input  frame_err,
      input  no_signal
   );

   modport slave (
      input  pwm_in,
      output level,
      output valid,
      output frame_err,
      output no_signal
   );
endinterface

// File: rtl/pwm_decode.sv
// pwm_decode
// Measures an asynchronous PWM waveform whose nominal frame is 2^WIDTH clk
// cycles. Each frame runs from one rising edge to the next; the number of
// high cycles in a correctly sized frame becomes the decoded level.
// Frames of the wrong length raise frame_err; a long absence of rising edges
// raises no_signal and reports a flat-line level (all-ones or zero).
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : pwm_decode_if.slave (pwm_in in; level/valid/frame_err/no_signal out)
// Parameters:
//   WIDTH  : level resolution (frame = 2^WIDTH cycles)
//   INVERT : 1 = treat pwm_in as active-low
module pwm_decode #(
   parameter int WIDTH  = 8,
   parameter bit INVERT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   pwm_decode_if.slave bus
);
   localparam int CW = WIDTH + 1;
   // Counters are one bit wider than a frame so that over-long frames and
   // the timeout can be told apart from a nominal frame.
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_TOP   = {{WIDTH{1'b1}}, 1'b0};
   localparam logic [CW-1:0] FRAME_LEN = {1'b1, {WIDTH{1'b0}}};
   localparam logic [CW-1:0] CNT_ONE   = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t           state_reg;
   logic             sync1_reg;
   logic             sync2_reg;
   logic             s_d_reg;
   logic [CW-1:0]    per_cnt_reg;
   logic [CW-1:0]    high_cnt_reg;
   logic [WIDTH-1:0] level_reg;
   logic             valid_reg;
   logic             frame_err_reg;
   logic             no_signal_reg;

   logic             s;
   logic             rise;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
      return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
   endfunction

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         s_d_reg   <= 1'b0;
      end else begin
         sync1_reg <= bus.pwm_in ^ INVERT;
         sync2_reg <= sync1_reg;
         s_d_reg   <= sync2_reg;
      end
   end

   assign s    = sync2_reg;
   assign rise = s & ~s_d_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         per_cnt_reg   <= '0;
         high_cnt_reg  <= '0;
         level_reg     <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         no_signal_reg <= 1'b0;
      end else begin
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         if (rise) begin
            // The rise cycle itself is the first (high) cycle of the new frame.
            per_cnt_reg  <= CNT_ONE;
            high_cnt_reg <= CNT_ONE;
            if (state_reg == IDLE) begin
               // No reference yet: the frame that just ended was partial.
               state_reg     <= MEASURE;
               no_signal_reg <= 1'b0;
            end else if (per_cnt_reg == FRAME_LEN) begin
               level_reg <= high_cnt_reg[WIDTH-1:0];
               valid_reg <= 1'b1;
            end else begin
               frame_err_reg <= 1'b1;
            end
         end else begin
            per_cnt_reg <= sat_inc(per_cnt_reg, 1'b1);
            if (state_reg == MEASURE) begin
               high_cnt_reg <= sat_inc(high_cnt_reg, s);
            end
            // Fires only on the step into saturation, so a flat line reports
            // once and then stays quiet until the next rise.
            if (per_cnt_reg == CNT_TOP) begin
               state_reg     <= IDLE;
               no_signal_reg <= 1'b1;
               valid_reg     <= 1'b1;
               level_reg     <= {WIDTH{s}};
            end
         end
      end
   end

   assign bus.level     = level_reg;
   assign bus.valid     = valid_reg;
   assign bus.frame_err = frame_err_reg;
   assign bus.no_signal = no_signal_reg;
endmodule

// File: tb/tb_pwm_decode.sv
// tb_pwm_decode
// Drives a normal-polarity and an inverted-polarity decoder from the same
// logical waveform and checks every cycle against a frame-level model:
// rising edges of the (two-cycle delayed) waveform delimit frames, the level
// is the count of high samples in a 256-cycle frame, and 510 cycles since the
// last reference point is a timeout.
module tb_pwm_decode;
   localparam int W      = 8;
   localparam int FRAME  = 1 << W;
   localparam int TOUT   = (1 << (W + 1)) - 2;
   localparam int LVLMAX = (1 << W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic drive = 1'b0;

   always #5 clk = ~clk;

   pwm_decode_if #(.WIDTH(W)) bus_n ();
   pwm_decode_if #(.WIDTH(W)) bus_i ();

   assign bus_n.pwm_in = drive;
   assign bus_i.pwm_in = ~drive;

   pwm_decode #(.WIDTH(W), .INVERT(1'b0)) dut_n (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_n.slave)
   );

   pwm_decode #(.WIDTH(W), .INVERT(1'b1)) dut_i (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_i.slave)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cur_step = 0;
   int run_id = 0;

   bit wave[$];

   // reference model state
   int m_origin;
   bit m_measure;
   bit m_valid;
   bit m_ferr;
   bit m_nosig;
   int m_level;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s run=%0d step=%0d got=%0d exp=%0d", tag, run_id, cur_step, got, exp);
      end
   endtask

   task automatic add_frame(input int period, input int high);
      for (int i = 0; i < period; i++) wave.push_back(i < high);
   endtask

   task automatic add_hold(input int n, input bit v);
      for (int i = 0; i < n; i++) wave.push_back(v);
   endtask

   task automatic add_random_frame(input bit odd_len);
      int period;
      period = (odd_len && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(150, 400)) : FRAME;
      add_frame(period, int'($urandom_range(1, period - 1)));
   endtask

   // Synchronised waveform as seen by the decoder at step j.
   function automatic bit sv_at(input int j);
      return (j >= 2) ? wave[j - 2] : 1'b0;
   endfunction

   function automatic void model_reset();
      m_origin  = 0;
      m_measure = 1'b0;
      m_valid   = 1'b0;
      m_ferr    = 1'b0;
      m_nosig   = 1'b0;
      m_level   = 0;
   endfunction

   function automatic void model_step(input int k);
      int highs;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      if (sv_at(k) && !sv_at(k - 1)) begin
         if (!m_measure) begin
            m_measure = 1'b1;
            m_nosig   = 1'b0;
         end else if (k - m_origin == FRAME) begin
            highs = 0;
            for (int j = m_origin; j < k; j++) highs += int'(sv_at(j));
            m_level = highs;
            m_valid = 1'b1;
         end else begin
            m_ferr = 1'b1;
         end
         m_origin = k;
      end else if (k - m_origin == TOUT) begin
         m_measure = 1'b0;
         m_nosig   = 1'b1;
         m_valid   = 1'b1;
         m_level   = sv_at(k) ? LVLMAX : 0;
      end
   endfunction

   task automatic compare_all();
      check("n_level", 32'(bus_n.level), m_level);
      check("n_valid", 32'(bus_n.valid), 32'(m_valid));
      check("n_frame_err", 32'(bus_n.frame_err), 32'(m_ferr));
      check("n_no_signal", 32'(bus_n.no_signal), 32'(m_nosig));
      check("i_level", 32'(bus_i.level), m_level);
      check("i_valid", 32'(bus_i.valid), 32'(m_valid));
      check("i_frame_err", 32'(bus_i.frame_err), 32'(m_ferr));
      check("i_no_signal", 32'(bus_i.no_signal), 32'(m_nosig));
      check("exclusive", 32'(bus_n.valid & bus_n.frame_err), 32'(0));
   endtask

   // Reset (with junk on pwm_in), check reset state, then play the wave.
   task automatic run_wave(input int rst_cycles);
      run_id++;
      reset = 1'b1;
      repeat (rst_cycles) begin
         @(negedge clk);
         drive = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      cur_step = -1;
      model_reset();
      compare_all();
      for (int k = 0; k < wave.size(); k++) begin
         @(negedge clk);
         reset = 1'b0;
         drive = wave[k];
         @(posedge clk);
         #1;
         cur_step = k;
         model_step(k);
         compare_all();
         if (m_valid || m_ferr)
            $display("[TB] run %0d step %0d %s level=%0d no_signal=%0d",
                     run_id, k, m_valid ? "valid" : "frame_err", m_level, m_nosig);
      end
   endtask

   initial begin
      // Lock at 64, random levels, short frame, extremes, boundary lengths,
      // flat-high timeout, recovery, flat-low timeout.
      wave.delete();
      add_hold(10, 1'b0);
      repeat (4) add_frame(FRAME, 64);
      repeat (4) add_random_frame(1'b0);
      add_frame(200, 50);
      repeat (2) add_frame(FRAME, 100);
      repeat (2) add_frame(FRAME, 255);
      repeat (2) add_frame(FRAME, 1);
      add_frame(510, 20);
      repeat (2) add_frame(FRAME, 30);
      add_frame(511, 20);
      repeat (2) add_frame(FRAME, 30);
      add_hold(600, 1'b1);
      add_hold(5, 1'b0);
      repeat (3) add_random_frame(1'b0);
      add_frame(FRAME, 70);
      add_hold(700, 1'b0);
      run_wave(3);

      // Held low from reset release.
      wave.delete();
      add_hold(700, 1'b0);
      run_wave(3);

      // Random frame lengths, ending mid-frame.
      wave.delete();
      add_hold(3, 1'b0);
      repeat (8) add_random_frame(1'b1);
      add_hold(int'($urandom_range(20, 200)), 1'b1);
      run_wave(4);

      // Mid-frame reset recovery, waveform high on the first sample.
      wave.delete();
      repeat (6) add_frame(FRAME, 64);
      run_wave(2);

      // Random stress with occasional flat lines.
      wave.delete();
      repeat (20) begin
         add_random_frame(1'b1);
         if ($urandom_range(0, 5) == 0) add_hold(int'($urandom_range(300, 700)), 1'($urandom_range(0, 1)));
      end
      run_wave(1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/pwm_decode.md
PWM_DECODE -- requirements
Module: pwm_decode

Interface
REQ-001 Parameter WIDTH, default 8: level resolution; nominal frame length is 2^WIDTH clk cycles.
REQ-002 Parameter INVERT, default 0: when 1, pwm_in is logically inverted before synchronisation.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 pwm_in  input  1  asynchronous PWM waveform to be decoded.
REQ-006 level  output  WIDTH  decoded duty level, registered.
REQ-007 valid  output  1  single-cycle strobe, level updated this cycle.
REQ-008 frame_err  output  1  single-cycle strobe, last frame period != 2^WIDTH.
REQ-009 no_signal  output  1  level flag, no rising edge seen within timeout.

Function
REQ-010 The block SHALL synchronise pwm_in (after optional inversion) through a 2-flop synchroniser; its output is s.
REQ-011 The block SHALL register s as s_d; rise = s & ~s_d.
REQ-012 The block SHALL keep per_cnt and high_cnt, each WIDTH+1 bits, saturating at 2^(WIDTH+1)-1, never wrapping.
REQ-013 FSM states: IDLE (no frame reference), MEASURE (counting a frame); reset state IDLE.
REQ-014 Every non-rise cycle, in both states: per_cnt += 1 (saturating).
REQ-015 Every non-rise cycle, in MEASURE only: high_cnt += s (saturating).
REQ-016 On rise in IDLE: go to MEASURE; per_cnt <= 1; high_cnt <= 1; clear no_signal; no capture, no strobe (partial frame).
REQ-017 On rise in MEASURE with per_cnt == 2^WIDTH: level <= high_cnt[WIDTH-1:0]; valid pulses 1 cycle; per_cnt <= 1; high_cnt <= 1.
REQ-018 On rise in MEASURE with per_cnt != 2^WIDTH: level holds; frame_err pulses 1 cycle; valid stays 0; counters <= 1.
REQ-019 Timeout: when per_cnt reaches 2^(WIDTH+1)-1 with no rise, the following actions SHALL occur in that cycle.
REQ-019a Timeout actions: go to IDLE; no_signal <= 1; valid pulses once; level <= all-ones if s==1, else 0.
REQ-020 After a timeout, per_cnt SHALL hold saturated in IDLE; valid and frame_err SHALL NOT pulse again until a new rise.
REQ-021 Latency: valid/frame_err SHALL assert exactly 3 clk edges after the first edge that samples pwm_in's frame-start high.
REQ-022 valid and frame_err SHALL never be asserted in the same cycle.
REQ-023 A rise coinciding with saturation SHALL be treated as a rise (REQ-016/017/018); the timeout SHALL NOT fire.

Reset
REQ-024 During reset the block SHALL load: level=0, valid=0, frame_err=0, no_signal=0, state IDLE.
REQ-025 During reset the block SHALL also load: per_cnt=0, high_cnt=0, synchroniser flops=0, s_d=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial measurement; the first rise after release only enters MEASURE.
REQ-027 Reset SHALL take priority over all other events in the same cycle.

Verification (WIDTH=8, INVERT=0 unless stated)
REQ-028 Continuous PWM, level 64, 256-cycle frames -> from 2nd full frame: valid every 256 cycles, level=64, frame_err never.
REQ-029 Level 255 (1 low cycle per frame) -> level=255; level 1 -> level=1; no frame_err.
REQ-030 pwm_in held low from reset release -> after 511 cycles: one valid, level=0, no_signal=1; no further strobes.
REQ-031 pwm_in held high after a lock -> timeout: level=255, no_signal=1; PWM resumes -> no_signal clears on 1st rise, valid after next full frame.
REQ-032 One frame of 200 cycles inserted -> one frame_err pulse, level unchanged; next 256-cycle frame -> valid.
REQ-033 INVERT=1 with inverted level-64 waveform -> level=64; reset mid-frame -> outputs 0, no strobe before one full post-reset frame.
